// File: rtl/audio_pkg.sv
// Shared constants and types for the audio output path.
package audio_pkg;

  localparam int unsigned AUDIO_DATA_W     = 16;
  localparam int unsigned I2S_SLOT_W_DEF   = 32;
  localparam int unsigned I2S_BCLK_DIV_DEF = 2;

  typedef enum logic {IDLE, RUN} tx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single level signal; resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/i2s_audio_tx.sv
// I2S transmitter: one-pair holding buffer feeding a frame shift register, serialized as
// BCLK/LRCK/DATA with data lagging LRCK by one bit clock.
module i2s_audio_tx
  import audio_pkg::*;
#(
  parameter int unsigned DATA_W   = AUDIO_DATA_W,
  parameter int unsigned SLOT_W   = I2S_SLOT_W_DEF,
  parameter int unsigned BCLK_DIV = I2S_BCLK_DIV_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              i2s_bclk,
  output logic              i2s_lrck,
  output logic              i2s_dat,
  output logic              frame_start,
  output logic              underrun
);

  localparam int unsigned FrameW = 2 * SLOT_W;
  localparam int unsigned KW     = $clog2(FrameW);
  localparam int unsigned DivW   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  localparam logic [KW-1:0]   KLast   = KW'(FrameW - 1);
  localparam logic [KW-1:0]   KRight  = KW'(SLOT_W);
  localparam logic [DivW-1:0] DivLast = DivW'(BCLK_DIV - 1);

  if (DATA_W < 1 || DATA_W > SLOT_W) begin : g_chk_data_w
    $error("i2s_audio_tx: DATA_W must be in 1..SLOT_W");
  end
  if (BCLK_DIV < 1) begin : g_chk_bclk_div
    $error("i2s_audio_tx: BCLK_DIV must be >= 1");
  end

  logic en;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (en)
  );

  tx_state_e state_q, state_d;
  logic      run;

  logic              bclk_q, lrck_q, dat_q;
  logic              frame_start_q, underrun_q;
  logic [KW-1:0]     k_q, k_next;
  logic [DivW-1:0]   div_q;
  logic [FrameW-1:0] sr_q, frame;
  logic              buf_full_q;
  logic [DATA_W-1:0] buf_l_q, buf_r_q;
  logic              div_wrap, bclk_fall, load, accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (en)  state_d = RUN;
      RUN:  if (!en) state_d = IDLE;
    endcase
  end

  // The datapath counts from the first enabled edge and clears on the first disabled one,
  // so it follows the next state rather than waiting a cycle for state_q.
  always_comb begin
    run     = (state_d == RUN);
    s_ready = en && !buf_full_q;
  end

  assign div_wrap  = (div_q == DivLast);
  assign bclk_fall = run && div_wrap && bclk_q;
  assign k_next    = (k_q == KLast) ? '0 : k_q + 1'b1;
  assign load      = bclk_fall && (k_next == '0);
  assign accept    = s_valid && s_ready;

  // Empty buffer at load yields an all-zero frame.
  always_comb begin
    frame = '0;
    if (buf_full_q) begin
      frame[FrameW-1 -: DATA_W] = buf_l_q;
      frame[SLOT_W-1 -: DATA_W] = buf_r_q;
    end
  end

  // k resets to its last value so the first falling edge lands on k=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      bclk_q        <= 1'b0;
      k_q           <= KLast;
      lrck_q        <= 1'b1;
      dat_q         <= 1'b0;
      sr_q          <= '0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      buf_full_q    <= 1'b0;
      buf_l_q       <= '0;
      buf_r_q       <= '0;
    end else if (!run) begin
      div_q         <= '0;
      bclk_q        <= 1'b0;
      k_q           <= KLast;
      lrck_q        <= 1'b1;
      dat_q         <= 1'b0;
      sr_q          <= '0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      buf_full_q    <= 1'b0;
      buf_l_q       <= '0;
      buf_r_q       <= '0;
    end else begin
      div_q <= div_wrap ? '0 : div_q + 1'b1;
      if (div_wrap) begin
        bclk_q <= ~bclk_q;
      end
      if (bclk_fall) begin
        k_q    <= k_next;
        lrck_q <= (k_next >= KRight);
        dat_q  <= sr_q[FrameW-1];
        sr_q   <= load ? frame : (sr_q << 1);
      end
      frame_start_q <= load;
      underrun_q    <= load && !buf_full_q;
      if (accept) begin
        buf_full_q <= 1'b1;
        buf_l_q    <= s_left;
        buf_r_q    <= s_right;
      end else if (load) begin
        buf_full_q <= 1'b0;
      end
    end
  end

  assign i2s_bclk    = bclk_q;
  assign i2s_lrck    = lrck_q;
  assign i2s_dat     = dat_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule
